scene_update_unit: RTL and testbench
====================================

// Module: scene_update_unit
// PURPOSE
//  Consumes decoded instructions (proctypes::DecodedInst) from the decoder and applies them to scene state.
//  Camera state is held in an internal register bank. Light and shape writes go out on write ports to their tables.
//  Frame and render commands are sequenced with a start/done handshake to the renderer.
//  Sits between the instruction decoder and the light/shape memories and the render core.
// PARAMETERS
//  CNT_W  16  width of the accepted-instruction counter (wraps)
// PORTS
//  clk_in           in   1    system clock
//  rst_in           in   1    synchronous, active-high reset
//  inst_in          in   75   proctypes::DecodedInst
//  inst_valid_in    in   1    inst_in valid
//  inst_ready_out   out  1    block can accept; transfer = valid&ready on rising clk_in
//  cam_out          out  208  proctypes::CameraState (13 x float16, cpXLocation..cpFovVer)
//  light_we_out     out  1    light table write strobe
//  light_addr_out   out  6    LightIndex
//  light_prop_out   out  5    LightProperty
//  light_data_out   out  16   float16 data
//  shape_we_out     out  1    shape property write strobe
//  shape_type_we_out out 1    shape type write strobe (opShapeInit)
//  shape_raw_out    out  1    write originates from opShapeData
//  shape_addr_out   out  19   ShapeIndex
//  shape_prop_out   out  5    ShapeProperty
//  shape_data_out   out  16   float16 data; for type writes {11'b0, ShapeType}
//  frame_start_out  out  1    one-cycle pulse on opFrame
//  render_start_out out  1    one-cycle pulse on opRender
//  render_done_in   in   1    renderer completion pulse
//  error_out        out  1    sticky: unsupported op or illegal property
//  inst_count_out   out  CNT_W  accepted-instruction count
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0, except inst_ready_out=1 from the first cycle after reset; cam_out all 0.
//  FSM states: IDLE, SLOT2, WAIT_RENDER. inst_ready_out = (state==IDLE).
//  Accept in IDLE at cycle N: slot-1 effect is registered and visible at N+1; inst_count_out increments at N+1.
//  Slot 2 (prop2/data2) is used iff prop2!=0. If used, go to SLOT2; its write appears at N+2; then return to IDLE.
//    If not used, stay in IDLE, which allows back-to-back accepts.
//  Slot 1 for camera/shape: prop==0 (cpNull/spNull) means no write. Slot 1 for light: prop 0 (lpType) is a real write.
//  opCameraSet: write cam field prop/prop2. Legal props are 1..13; any prop >13 gives no write and sets error_out.
//  opLightSet: light_we_out=1 with lIndex/prop/data, then prop2/data2 if slot 2 is used. Props >8 set error_out with no write.
//  opShapeSet: shape_we_out with sIndex/prop/data, then slot 2. Props >10 set error_out.
//  opShapeData: same as opShapeSet with shape_raw_out=1 and no property range check.
//  opShapeInit: single cycle; shape_type_we_out=1, shape_data_out={11'b0,sType}; prop fields ignored.
//  opFrame: frame_start_out=1 at N+1; stay in IDLE.
//  opRender: render_start_out=1 at N+1, then enter WAIT_RENDER.
//    render_done_in is ignored in the cycle render_start_out is high.
//    On a later done, return to IDLE; ready is high the next cycle.
//  opUnsupported: no effect other than error_out=1; the instruction is still counted.
//  All strobes and pulses are 1 cycle. Address/prop/data outputs hold their last value when strobes are low.
//  Reset mid-operation (SLOT2/WAIT_RENDER) abandons the instruction: pending slot 2 is not written and no render_start re-issue.
//  inst_count_out wraps from 2^CNT_W-1 to 0.
// CONFIGURATION
//  SCENE_UPDATE_SHADOW_CAM_EN defined:
//    camera writes go to a shadow bank.
//    The shadow bank is copied to cam_out in the same cycle render_start_out pulses.
//    cam_out is stable for the whole render.
//  Not defined: camera writes update cam_out directly at N+1 (N+2 for slot 2).
// STRUCTURE
//  proctypes package additions:
//    CameraState packed struct;
//    UpdState enum {usIdle,usSlot2,usWaitRender};
//    CAM_PROP_MAX=13, LIGHT_PROP_MAX=8, SHAPE_PROP_MAX=10.
//  Sub-module cam_reg_bank: the 13 float16 registers with indexed write port.
//    It also holds the shadow copy and commit under SCENE_UPDATE_SHADOW_CAM_EN.
// TESTING
//  opCameraSet prop=1 data=3C00, prop2=12 data2=4000 -> ready low 1 cycle; cam x=3C00 at N+1, fovHor=4000 at N+2.
//  Back-to-back opLightSet lIndex=5 prop=7 data=1234 prop2=0 -> light_we on 2 consecutive cycles (addr 5, prop 7, 1234).
//    ready stays high; count +2.
//  opRender; render_done_in at N+1 and N+10 -> start pulse N+1; N+1 done ignored; ready low until N+10, high at N+11.
//  opCameraSet prop=20 or opUnsupported -> no strobes, cam unchanged, error_out=1, held until reset.
//  Reset asserted in WAIT_RENDER and in SLOT2 -> all outputs 0, no slot-2 write, ready=1 after reset deasserts.
//  Shadow on: write cam x=3C00, then opRender -> cam_out x stays 0 until the render_start cycle, then 3C00.
//  Count wrap: CNT_W=4, 16 accepts -> count returns to 0.

Source files
------------

// File: rtl/proctypes_pkg.sv
// Shared processor types: decoded instruction layout, camera state, and the
// scene-update FSM encoding and property limits.
package proctypes;

  typedef enum logic [2:0] {
    opUnsupported = 3'd0,
    opCameraSet   = 3'd1,
    opLightSet    = 3'd2,
    opShapeSet    = 3'd3,
    opShapeData   = 3'd4,
    opShapeInit   = 3'd5,
    opFrame       = 3'd6,
    opRender      = 3'd7
  } OpCode;

  typedef logic [5:0]  LightIndex;
  typedef logic [18:0] ShapeIndex;
  typedef logic [4:0]  ShapeType;
  typedef logic [4:0]  PropCode;
  typedef logic [15:0] Float16;

  // 75-bit decoded instruction; op sits in the top bits.
  typedef struct packed {
    OpCode     op;
    LightIndex lIndex;
    ShapeIndex sIndex;
    ShapeType  sType;
    PropCode   prop;
    Float16    data;
    PropCode   prop2;
    Float16    data2;
  } DecodedInst;

  // Camera property p (1..13) maps to field p-1 in declaration order.
  typedef struct packed {
    Float16 xLocation;
    Float16 yLocation;
    Float16 zLocation;
    Float16 xLookAt;
    Float16 yLookAt;
    Float16 zLookAt;
    Float16 xUp;
    Float16 yUp;
    Float16 zUp;
    Float16 nearPlane;
    Float16 farPlane;
    Float16 fovHor;
    Float16 fovVer;
  } CameraState;

  typedef enum logic [1:0] {
    usIdle       = 2'd0,
    usSlot2      = 2'd1,
    usWaitRender = 2'd2
  } UpdState;

  localparam int      CAM_REGS       = 13;
  localparam PropCode CAM_PROP_MAX   = 5'd13;
  localparam PropCode LIGHT_PROP_MAX = 5'd8;
  localparam PropCode SHAPE_PROP_MAX = 5'd10;

  // A second property write follows only for table/camera ops with prop2 != 0.
  function automatic logic usesSlot2(input DecodedInst inst);
    return (inst.op inside {opCameraSet, opLightSet, opShapeSet, opShapeData}) &&
           (inst.prop2 != 5'd0);
  endfunction

endpackage

// File: rtl/scene_update_unit_cam_reg_bank.sv
// Camera register bank: 13 float16 fields with an indexed write port.
// Build option SCENE_UPDATE_SHADOW_CAM_EN: writes land in a shadow copy that
// is transferred to the visible state on commit (render start).
module cam_reg_bank
  import proctypes::*;
(
  input  logic       clk,
  input  logic       srst,
  input  logic       wrEn,
  input  PropCode    wrProp,
  input  Float16     wrData,
  input  logic       commit,
  output CameraState camState
);

  logic [CAM_REGS*16-1:0] camVec;

  genvar gi;
  generate
    for (gi = 0; gi < CAM_REGS; gi++) begin : gField
      Float16 fieldReg;

      // Load this field when its property code is addressed.
      always_ff @(posedge clk) begin
        if (srst) fieldReg <= '0;
        else if (wrEn && (wrProp == 5'(gi + 1))) fieldReg <= wrData;
      end

`ifdef SCENE_UPDATE_SHADOW_CAM_EN
      Float16 visibleReg;

      // Visible copy only moves on commit so the renderer sees a frozen camera.
      always_ff @(posedge clk) begin
        if (srst) visibleReg <= '0;
        else if (commit) visibleReg <= fieldReg;
      end

      assign camVec[(CAM_REGS-1-gi)*16 +: 16] = visibleReg;
`else
      assign camVec[(CAM_REGS-1-gi)*16 +: 16] = fieldReg;
`endif
    end
  endgenerate

`ifndef SCENE_UPDATE_SHADOW_CAM_EN
  wire unusedCommit = commit;
`endif

  assign camState = camVec;

endmodule

// File: rtl/scene_update_unit.sv
// Scene update unit: applies decoded instructions to camera state and drives
// light/shape table writes and the frame/render handshake.
// Build option SCENE_UPDATE_SHADOW_CAM_EN: camera writes are staged and
// committed to cam_out when render_start_out pulses.
module scene_update_unit
  import proctypes::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  DecodedInst       inst_in,
  input  logic             inst_valid_in,
  output logic             inst_ready_out,
  output CameraState       cam_out,
  output logic             light_we_out,
  output logic [5:0]       light_addr_out,
  output logic [4:0]       light_prop_out,
  output logic [15:0]      light_data_out,
  output logic             shape_we_out,
  output logic             shape_type_we_out,
  output logic             shape_raw_out,
  output logic [18:0]      shape_addr_out,
  output logic [4:0]       shape_prop_out,
  output logic [15:0]      shape_data_out,
  output logic             frame_start_out,
  output logic             render_start_out,
  input  logic             render_done_in,
  output logic             error_out,
  output logic [CNT_W-1:0] inst_count_out
);

  UpdState   stateReg, stateNext;
  OpCode     pendOp;
  LightIndex pendLIdx;
  ShapeIndex pendSIdx;
  PropCode   pendProp;
  Float16    pendData;

  logic      accept, slotActive, slotFirst;
  OpCode     slotOp;
  LightIndex slotLIdx;
  ShapeIndex slotSIdx;
  PropCode   slotProp;
  Float16    slotData;
  logic      lightWeNext, shapeWeNext, shapeTypeWeNext, frameNext, renderNext;
  logic      camWe, errSet, camCommit;

  assign inst_ready_out = (stateReg == usIdle);
  assign accept         = inst_valid_in && inst_ready_out;
  assign camCommit      = accept && (inst_in.op == opRender);

  // State register.
  always_ff @(posedge clk_in) begin
    if (rst_in) stateReg <= usIdle;
    else        stateReg <= stateNext;
  end

  // Next state: slot 2 takes one extra cycle; render waits for a done that
  // arrives after the start pulse.
  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      usIdle: begin
        if (accept) begin
          if (inst_in.op == opRender) stateNext = usWaitRender;
          else if (usesSlot2(inst_in)) stateNext = usSlot2;
        end
      end
      usSlot2:      stateNext = usIdle;
      usWaitRender: if (render_done_in && !render_start_out) stateNext = usIdle;
      default:      stateNext = usIdle;
    endcase
  end

  // Select which property slot is being applied this cycle.
  always_comb begin
    slotActive = accept;
    slotFirst  = 1'b1;
    slotOp     = inst_in.op;
    slotLIdx   = inst_in.lIndex;
    slotSIdx   = inst_in.sIndex;
    slotProp   = inst_in.prop;
    slotData   = inst_in.data;
    if (stateReg == usSlot2) begin
      slotActive = 1'b1;
      slotFirst  = 1'b0;
      slotOp     = pendOp;
      slotLIdx   = pendLIdx;
      slotSIdx   = pendSIdx;
      slotProp   = pendProp;
      slotData   = pendData;
    end
  end

  // Output decode: strobes, camera write and error for the active slot.
  always_comb begin
    lightWeNext     = 1'b0;
    shapeWeNext     = 1'b0;
    shapeTypeWeNext = 1'b0;
    frameNext       = 1'b0;
    renderNext      = 1'b0;
    camWe           = 1'b0;
    errSet          = 1'b0;
    if (slotActive) begin
      case (slotOp)
        opCameraSet: begin
          if (slotProp != 5'd0) begin
            if (slotProp <= CAM_PROP_MAX) camWe = 1'b1;
            else                          errSet = 1'b1;
          end
        end
        opLightSet: begin
          // Property 0 (lpType) is a genuine light write.
          if (slotProp <= LIGHT_PROP_MAX) lightWeNext = 1'b1;
          else                            errSet = 1'b1;
        end
        opShapeSet: begin
          if (slotProp != 5'd0) begin
            if (slotProp <= SHAPE_PROP_MAX) shapeWeNext = 1'b1;
            else                            errSet = 1'b1;
          end
        end
        opShapeData:   if (slotProp != 5'd0) shapeWeNext = 1'b1;
        opShapeInit:   shapeTypeWeNext = slotFirst;
        opFrame:       frameNext = slotFirst;
        opRender:      renderNext = slotFirst;
        opUnsupported: errSet = 1'b1;
        default:       errSet = 1'b1;
      endcase
    end
  end

  // Registered outputs; address/prop/data hold between strobes.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      light_we_out      <= 1'b0;
      light_addr_out    <= '0;
      light_prop_out    <= '0;
      light_data_out    <= '0;
      shape_we_out      <= 1'b0;
      shape_type_we_out <= 1'b0;
      shape_raw_out     <= 1'b0;
      shape_addr_out    <= '0;
      shape_prop_out    <= '0;
      shape_data_out    <= '0;
      frame_start_out   <= 1'b0;
      render_start_out  <= 1'b0;
      error_out         <= 1'b0;
      inst_count_out    <= '0;
      pendOp            <= opUnsupported;
      pendLIdx          <= '0;
      pendSIdx          <= '0;
      pendProp          <= '0;
      pendData          <= '0;
    end else begin
      light_we_out      <= lightWeNext;
      shape_we_out      <= shapeWeNext;
      shape_type_we_out <= shapeTypeWeNext;
      frame_start_out   <= frameNext;
      render_start_out  <= renderNext;
      if (lightWeNext) begin
        light_addr_out <= slotLIdx;
        light_prop_out <= slotProp;
        light_data_out <= slotData;
      end
      if (shapeWeNext) begin
        shape_addr_out <= slotSIdx;
        shape_prop_out <= slotProp;
        shape_data_out <= slotData;
        shape_raw_out  <= (slotOp == opShapeData);
      end else if (shapeTypeWeNext) begin
        shape_addr_out <= slotSIdx;
        shape_data_out <= {11'b0, inst_in.sType};
        shape_raw_out  <= 1'b0;
      end
      if (errSet) error_out <= 1'b1;
      if (accept) begin
        inst_count_out <= inst_count_out + 1'b1;
        pendOp         <= inst_in.op;
        pendLIdx       <= inst_in.lIndex;
        pendSIdx       <= inst_in.sIndex;
        pendProp       <= inst_in.prop2;
        pendData       <= inst_in.data2;
      end
    end
  end

  cam_reg_bank uCamBank (
    .clk      (clk_in),
    .srst     (rst_in),
    .wrEn     (camWe),
    .wrProp   (slotProp),
    .wrData   (slotData),
    .commit   (camCommit),
    .camState (cam_out)
  );

endmodule

// File: tb/tb_scene_update_unit.sv
// Scoreboard bench for scene_update_unit: expected strobe events are queued at
// send time and popped by a negedge monitor; tasks check state inline.
`timescale 1ns/1ps
module tb_scene_update_unit;
  import proctypes::*;

  localparam int CNT_W = 4;
`ifdef SCENE_UPDATE_SHADOW_CAM_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  localparam int K_LIGHT = 1, K_SHAPE = 2, K_STYPE = 3, K_FRAME = 4, K_RENDER = 5;

  logic clk = 1'b0, rst = 1'b1;
  DecodedInst inst_in = '0;
  logic inst_valid_in = 1'b0, render_done_in = 1'b0;
  logic inst_ready_out, light_we_out, shape_we_out, shape_type_we_out, shape_raw_out;
  logic frame_start_out, render_start_out, error_out;
  CameraState cam_out;
  logic [5:0] light_addr_out;
  logic [4:0] light_prop_out, shape_prop_out;
  logic [15:0] light_data_out, shape_data_out;
  logic [18:0] shape_addr_out;
  logic [CNT_W-1:0] inst_count_out;

  scene_update_unit #(.CNT_W(CNT_W)) dut (
    .clk_in(clk), .rst_in(rst), .inst_in(inst_in), .inst_valid_in(inst_valid_in),
    .inst_ready_out(inst_ready_out), .cam_out(cam_out),
    .light_we_out(light_we_out), .light_addr_out(light_addr_out),
    .light_prop_out(light_prop_out), .light_data_out(light_data_out),
    .shape_we_out(shape_we_out), .shape_type_we_out(shape_type_we_out),
    .shape_raw_out(shape_raw_out), .shape_addr_out(shape_addr_out),
    .shape_prop_out(shape_prop_out), .shape_data_out(shape_data_out),
    .frame_start_out(frame_start_out), .render_start_out(render_start_out),
    .render_done_in(render_done_in), .error_out(error_out),
    .inst_count_out(inst_count_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [18:0] addr;
    logic [4:0]  prop;
    logic [15:0] data;
    logic        raw;
  } Evt;

  Evt expQ[$];
  int passCnt = 0, totalCnt = 0;
  logic [15:0] camLive [13];
  logic [15:0] camVis  [13];
  logic [CNT_W-1:0] expCount = '0;

  wire [285:0] allOut = {light_we_out, shape_we_out, shape_type_we_out, shape_raw_out,
                         frame_start_out, render_start_out, error_out, light_addr_out,
                         light_prop_out, light_data_out, shape_addr_out, shape_prop_out,
                         shape_data_out, inst_count_out, cam_out};

  function automatic DecodedInst mk(input OpCode op, input logic [5:0] li, input logic [18:0] si,
                                    input logic [4:0] st, input logic [4:0] p, input logic [15:0] d,
                                    input logic [4:0] p2, input logic [15:0] d2);
    DecodedInst r;
    r.op = op; r.lIndex = li; r.sIndex = si; r.sType = st;
    r.prop = p; r.data = d; r.prop2 = p2; r.data2 = d2;
    return r;
  endfunction

  function automatic void pushEvt(input int k, input logic [18:0] a, input logic [4:0] p,
                                  input logic [15:0] d, input logic raw);
    Evt e;
    e.kind = k; e.addr = a; e.prop = p; e.data = d; e.raw = raw;
    expQ.push_back(e);
  endfunction

  // Camera model packed with field 0 (xLocation) in the top bits.
  function automatic logic [207:0] camExp();
    logic [207:0] v;
    for (int i = 0; i < 13; i++) v[(12-i)*16 +: 16] = camVis[i];
    return v;
  endfunction

  function automatic void camWrite(input int prop, input logic [15:0] d);
    camLive[prop-1] = d;
    if (!SHADOW) camVis[prop-1] = d;
  endfunction

  function automatic void camCommit();
    for (int i = 0; i < 13; i++) camVis[i] = camLive[i];
  endfunction

  function automatic void modelReset();
    for (int i = 0; i < 13; i++) begin camLive[i] = '0; camVis[i] = '0; end
    expCount = '0;
  endfunction

  task automatic sendInst(input DecodedInst inst);
    int guard = 0;
    while (!inst_ready_out && guard < 50) begin @(negedge clk); guard++; end
    if (!inst_ready_out) begin
      totalCnt++;
      $display("FAIL send_ready_timeout: ready=%b required 1", inst_ready_out);
    end
    inst_in = inst;
    inst_valid_in = 1'b1;
    @(negedge clk);
    inst_valid_in = 1'b0;
    expCount++;
  endtask

  // Strobe monitor: each strobe must match the oldest queued expectation.
  int nStrobe, obsKind;
  logic [18:0] obsAddr;
  logic [4:0] obsProp;
  logic [15:0] obsData;
  logic obsRaw;
  Evt e;
  always @(negedge clk) begin
    if (!rst) begin
      nStrobe = int'(light_we_out) + int'(shape_we_out) + int'(shape_type_we_out) +
                int'(frame_start_out) + int'(render_start_out);
      if (nStrobe != 0) begin
        obsKind = light_we_out ? K_LIGHT : shape_we_out ? K_SHAPE :
                  shape_type_we_out ? K_STYPE : frame_start_out ? K_FRAME : K_RENDER;
        obsAddr = '0; obsProp = '0; obsData = '0; obsRaw = 1'b0;
        if (obsKind == K_LIGHT) begin
          obsAddr = {13'd0, light_addr_out}; obsProp = light_prop_out; obsData = light_data_out;
        end else if (obsKind == K_SHAPE || obsKind == K_STYPE) begin
          obsAddr = shape_addr_out; obsProp = shape_prop_out;
          obsData = shape_data_out; obsRaw = shape_raw_out;
        end
        totalCnt++;
        if (expQ.size() == 0) begin
          $display("FAIL strobe_unexpected: kind=%0d addr=%h data=%h, required no strobe",
                   obsKind, obsAddr, obsData);
        end else begin
          e = expQ.pop_front();
          if (nStrobe != 1 || obsKind != e.kind || obsAddr !== e.addr || obsData !== e.data ||
              obsRaw !== e.raw || (obsKind != K_STYPE && obsProp !== e.prop))
            $display("FAIL strobe_event: got n=%0d kind=%0d addr=%h prop=%0d data=%h raw=%b, required kind=%0d addr=%h prop=%0d data=%h raw=%b",
                     nStrobe, obsKind, obsAddr, obsProp, obsData, obsRaw,
                     e.kind, e.addr, e.prop, e.data, e.raw);
          else passCnt++;
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    totalCnt++;
    if (allOut !== '0) $display("FAIL reset_outputs: got %h required 0", allOut);
    else passCnt++;
    rst = 1'b0;
    modelReset();
    @(negedge clk);
    totalCnt++;
    if (inst_ready_out !== 1'b1 || allOut !== '0)
      $display("FAIL reset_ready: ready=%b outs=%h required ready=1 outs=0", inst_ready_out, allOut);
    else passCnt++;
  endtask

  task automatic test_camera();
    sendInst(mk(opCameraSet, 6'd0, 19'd0, 5'd0, 5'd1, 16'h3C00, 5'd12, 16'h4000));
    camWrite(1, 16'h3C00);
    totalCnt++;
    if (inst_ready_out !== 1'b0 || cam_out !== camExp())
      $display("FAIL cam_slot1: ready=%b cam=%h required ready=0 cam=%h", inst_ready_out, cam_out, camExp());
    else passCnt++;
    @(negedge clk);
    camWrite(12, 16'h4000);
    totalCnt++;
    if (inst_ready_out !== 1'b1 || cam_out !== camExp() || inst_count_out !== expCount || error_out !== 1'b0)
      $display("FAIL cam_slot2: ready=%b cam=%h cnt=%0d err=%b required ready=1 cam=%h cnt=%0d err=0",
               inst_ready_out, cam_out, inst_count_out, error_out, camExp(), expCount);
    else passCnt++;
  endtask

  task automatic test_back_to_back();
    pushEvt(K_LIGHT, 19'd5, 5'd7, 16'h1234, 1'b0);
    pushEvt(K_LIGHT, 19'd5, 5'd7, 16'h1234, 1'b0);
    sendInst(mk(opLightSet, 6'd5, 19'd0, 5'd0, 5'd7, 16'h1234, 5'd0, 16'h0));
    totalCnt++;
    if (inst_ready_out !== 1'b1) $display("FAIL b2b_ready: got %b required 1", inst_ready_out);
    else passCnt++;
    sendInst(mk(opLightSet, 6'd5, 19'd0, 5'd0, 5'd7, 16'h1234, 5'd0, 16'h0));
    totalCnt++;
    if (inst_count_out !== expCount) $display("FAIL b2b_count: got %0d required %0d", inst_count_out, expCount);
    else passCnt++;
    // lpType (prop 0) is written, followed by slot 2 with prop 8.
    pushEvt(K_LIGHT, 19'd63, 5'd0, 16'hABCD, 1'b0);
    pushEvt(K_LIGHT, 19'd63, 5'd8, 16'h0F0F, 1'b0);
    sendInst(mk(opLightSet, 6'd63, 19'd0, 5'd0, 5'd0, 16'hABCD, 5'd8, 16'h0F0F));
    repeat (2) @(negedge clk);
    totalCnt++;
    if (light_we_out !== 1'b0 || light_addr_out !== 6'd63 || light_prop_out !== 5'd8 || light_data_out !== 16'h0F0F)
      $display("FAIL light_hold: we=%b addr=%0d prop=%0d data=%h required we=0 addr=63 prop=8 data=0f0f",
               light_we_out, light_addr_out, light_prop_out, light_data_out);
    else passCnt++;
  endtask

  task automatic test_shape();
    pushEvt(K_SHAPE, 19'h7FFFF, 5'd10, 16'hAAAA, 1'b0);
    sendInst(mk(opShapeSet, 6'd0, 19'h7FFFF, 5'd0, 5'd10, 16'hAAAA, 5'd0, 16'h0));
    pushEvt(K_SHAPE, 19'd3, 5'd25, 16'h5555, 1'b1);
    pushEvt(K_SHAPE, 19'd3, 5'd31, 16'h0F0F, 1'b1);
    sendInst(mk(opShapeData, 6'd0, 19'd3, 5'd0, 5'd25, 16'h5555, 5'd31, 16'h0F0F));
    pushEvt(K_STYPE, 19'd100, 5'd0, 16'h0011, 1'b0);
    sendInst(mk(opShapeInit, 6'd0, 19'd100, 5'd17, 5'd3, 16'h9999, 5'd4, 16'h8888));
    totalCnt++;
    if (inst_ready_out !== 1'b1) $display("FAIL shape_init_ready: got %b required 1", inst_ready_out);
    else passCnt++;
    sendInst(mk(opShapeSet, 6'd0, 19'd7, 5'd0, 5'd0, 16'h1111, 5'd0, 16'h0));
    @(negedge clk);
    totalCnt++;
    if (error_out !== 1'b0 || inst_count_out !== expCount || expQ.size() != 0)
      $display("FAIL shape_end: err=%b cnt=%0d pending=%0d required err=0 cnt=%0d pending=0",
               error_out, inst_count_out, expQ.size(), expCount);
    else passCnt++;
  endtask

  task automatic test_frame();
    pushEvt(K_FRAME, 19'd0, 5'd0, 16'h0, 1'b0);
    sendInst(mk(opFrame, 6'd1, 19'd1, 5'd1, 5'd1, 16'h1, 5'd1, 16'h1));
    totalCnt++;
    if (inst_ready_out !== 1'b1) $display("FAIL frame_ready: got %b required 1", inst_ready_out);
    else passCnt++;
  endtask

  task automatic test_render();
    sendInst(mk(opCameraSet, 6'd0, 19'd0, 5'd0, 5'd2, 16'h4200, 5'd0, 16'h0));
    camWrite(2, 16'h4200);
    totalCnt++;
    if (cam_out !== camExp()) $display("FAIL render_cam_before: got %h required %h", cam_out, camExp());
    else passCnt++;
    pushEvt(K_RENDER, 19'd0, 5'd0, 16'h0, 1'b0);
    sendInst(mk(opRender, 6'd0, 19'd0, 5'd0, 5'd0, 16'h0, 5'd0, 16'h0));
    camCommit();
    totalCnt++;
    if (cam_out !== camExp() || inst_ready_out !== 1'b0)
      $display("FAIL render_start_cam: cam=%h ready=%b required cam=%h ready=0", cam_out, inst_ready_out, camExp());
    else passCnt++;
    render_done_in = 1'b1;
    @(negedge clk);
    render_done_in = 1'b0;
    for (int c = 2; c <= 10; c++) begin
      totalCnt++;
      if (inst_ready_out !== 1'b0 || cam_out !== camExp())
        $display("FAIL render_wait_n%0d: ready=%b cam=%h required ready=0 cam=%h", c, inst_ready_out, cam_out, camExp());
      else passCnt++;
      if (c == 10) render_done_in = 1'b1;
      @(negedge clk);
    end
    render_done_in = 1'b0;
    totalCnt++;
    if (inst_ready_out !== 1'b1) $display("FAIL render_done_ready: got %b required 1", inst_ready_out);
    else passCnt++;
  endtask

  task automatic test_error();
    sendInst(mk(opCameraSet, 6'd0, 19'd0, 5'd0, 5'd20, 16'hFFFF, 5'd0, 16'h0));
    totalCnt++;
    if (error_out !== 1'b1 || cam_out !== camExp())
      $display("FAIL err_cam_prop: err=%b cam=%h required err=1 cam=%h", error_out, cam_out, camExp());
    else passCnt++;
    sendInst(mk(opUnsupported, 6'd2, 19'd2, 5'd2, 5'd2, 16'h2, 5'd2, 16'h2));
    sendInst(mk(opLightSet, 6'd9, 19'd0, 5'd0, 5'd9, 16'h7777, 5'd0, 16'h0));
    repeat (3) @(negedge clk);
    totalCnt++;
    if (error_out !== 1'b1 || inst_count_out !== expCount || cam_out !== camExp() || expQ.size() != 0)
      $display("FAIL err_sticky: err=%b cnt=%0d cam=%h pending=%0d required err=1 cnt=%0d cam=%h pending=0",
               error_out, inst_count_out, cam_out, expQ.size(), expCount, camExp());
    else passCnt++;
  endtask

  task automatic test_reset_midop();
    pushEvt(K_RENDER, 19'd0, 5'd0, 16'h0, 1'b0);
    sendInst(mk(opRender, 6'd0, 19'd0, 5'd0, 5'd0, 16'h0, 5'd0, 16'h0));
    #2 rst = 1'b1;
    @(negedge clk);
    modelReset();
    totalCnt++;
    if (allOut !== '0) $display("FAIL rst_wait_render: outs=%h required 0", allOut);
    else passCnt++;
    #2 rst = 1'b0;
    @(negedge clk);
    totalCnt++;
    if (inst_ready_out !== 1'b1 || render_start_out !== 1'b0)
      $display("FAIL rst_wait_render_ready: ready=%b start=%b required ready=1 start=0", inst_ready_out, render_start_out);
    else passCnt++;
    pushEvt(K_LIGHT, 19'd4, 5'd1, 16'h1111, 1'b0);
    sendInst(mk(opLightSet, 6'd4, 19'd0, 5'd0, 5'd1, 16'h1111, 5'd2, 16'h2222));
    #2 rst = 1'b1;
    @(negedge clk);
    modelReset();
    totalCnt++;
    if (allOut !== '0) $display("FAIL rst_slot2: outs=%h required 0", allOut);
    else passCnt++;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    totalCnt++;
    if (inst_ready_out !== 1'b1 || allOut !== '0 || expQ.size() != 0)
      $display("FAIL rst_slot2_after: ready=%b outs=%h pending=%0d required ready=1 outs=0 pending=0",
               inst_ready_out, allOut, expQ.size());
    else passCnt++;
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 15; i++) begin
      pushEvt(K_FRAME, 19'd0, 5'd0, 16'h0, 1'b0);
      sendInst(mk(opFrame, 6'd0, 19'd0, 5'd0, 5'd0, 16'h0, 5'd0, 16'h0));
    end
    totalCnt++;
    if (inst_count_out !== 4'hF) $display("FAIL wrap_max: got %0d required 15", inst_count_out);
    else passCnt++;
    pushEvt(K_FRAME, 19'd0, 5'd0, 16'h0, 1'b0);
    sendInst(mk(opFrame, 6'd0, 19'd0, 5'd0, 5'd0, 16'h0, 5'd0, 16'h0));
    totalCnt++;
    if (inst_count_out !== 4'h0 || inst_count_out !== expCount)
      $display("FAIL wrap_zero: got %0d required 0", inst_count_out);
    else passCnt++;
  endtask

  initial begin
    modelReset();
    @(negedge clk);
    test_reset();
    test_camera();
    test_back_to_back();
    test_shape();
    test_frame();
    test_render();
    test_error();
    test_reset_midop();
    test_wrap();
    repeat (3) @(negedge clk);
    totalCnt++;
    if (expQ.size() != 0) $display("FAIL missing_strobes: pending=%0d required 0", expQ.size());
    else passCnt++;
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
